// File: rtl/reg_fanout_pkg.sv
// Shared definitions for the register fan-out bank: mode encodings and the
// round-robin target search used by the top-level selection logic.
package reg_fanout_pkg;

    localparam logic MODE_BCAST = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned MAX_NCH = 16;
    localparam int unsigned IDX_W   = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First enabled channel at or after ptr, searching upward modulo nch (ptr < nch).
    function automatic rr_pick_t next_enabled(
        input logic [IDX_W-1:0]   ptr,
        input logic [MAX_NCH-1:0] en,
        input int unsigned        nch
    );
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 0; k < MAX_NCH; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= nch) begin
                cand = cand - nch;
            end
            if ((k < nch) && !pick.found && en[IDX_W'(cand)]) begin
                pick.found = 1'b1;
                pick.idx   = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_fanout_lane.sv
// One channel of the fan-out bank: DEPTH-cycle delay line ending in a
// held output register with a one-cycle update strobe.
module reg_fanout_lane
    import reg_fanout_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sel,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic             fin_vld_c;
    logic [WIDTH-1:0] fin_dat_c;

    generate
        if (DEPTH == 1) begin : g_direct
            // The output register itself is the only stage.
            assign fin_vld_c = sel;
            assign fin_dat_c = d;
        end else begin : g_pipe
            localparam int unsigned NS = DEPTH - 1;

            logic [NS-1:0]    vld_r;
            logic [WIDTH-1:0] dat_r [NS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= '0;
                end else if (clr) begin
                    vld_r <= '0;
                end else begin
                    vld_r[0] <= sel;
                    for (int unsigned i = 1; i < NS; i++) begin
                        vld_r[i] <= vld_r[i-1];
                    end
                end
            end

            // Data stages need no reset; only the valid bits qualify them.
            always_ff @(posedge clk) begin
                dat_r[0] <= d;
                for (int unsigned i = 1; i < NS; i++) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end

            assign fin_vld_c = vld_r[NS-1];
            assign fin_dat_c = dat_r[NS-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RST_VAL;
            q_valid <= 1'b0;
        end else if (clr) begin
            q       <= RST_VAL;
            q_valid <= 1'b0;
        end else begin
            q_valid <= fin_vld_c;
            if (fin_vld_c) begin
                q <= fin_dat_c;
            end
        end
    end

endmodule

// File: rtl/reg_fanout_bank.sv
// Multi-channel register bank: distributes each accepted beat to all enabled
// channels (broadcast) or to the next enabled channel in turn (round-robin).
module reg_fanout_bank
    import reg_fanout_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      NCH     = 3,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clr,
    input  logic                                    mode,
    input  logic [NCH-1:0]                          ch_en,
    input  logic                                    d_valid,
    input  logic [WIDTH-1:0]                        d,
    output logic [NCH*WIDTH-1:0]                    q,
    output logic [NCH-1:0]                          q_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rr_ptr
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           accept_c;
    rr_pick_t       pick_c;
    logic [NCH-1:0] sel_c;
    logic [PW-1:0]  rr_ptr_nxt_c;

    assign accept_c = d_valid & ~clr;
    assign pick_c   = next_enabled(IDX_W'(rr_ptr), MAX_NCH'(ch_en), NCH);

    // Channel selection for the current beat and the advanced round-robin pointer.
    always_comb begin
        sel_c        = '0;
        rr_ptr_nxt_c = rr_ptr;
        if (accept_c) begin
            if (mode == MODE_BCAST) begin
                sel_c = ch_en;
            end else if (pick_c.found) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    sel_c[i] = (pick_c.idx == IDX_W'(i));
                end
                rr_ptr_nxt_c = (pick_c.idx == IDX_W'(NCH - 1))
                             ? '0 : PW'(pick_c.idx + IDX_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (clr) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt_c;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lane
            reg_fanout_lane #(
                .WIDTH   (WIDTH),
                .DEPTH   (DEPTH),
                .RST_VAL (RST_VAL)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .sel     (sel_c[i]),
                .d       (d),
                .q       (q[i*WIDTH +: WIDTH]),
                .q_valid (q_valid[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_fanout_bank.sv
// Bench for reg_fanout_bank: DEPTH=1 and DEPTH=3 instances share one stimulus
// stream and are compared each cycle against an event-queue reference model.
module tb_reg_fanout_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NCH   = 3;
    localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             mode = 1'b0;
    logic [NCH-1:0]   ch_en = '0;
    logic             d_valid = 1'b0;
    logic [WIDTH-1:0] d = '0;

    logic [NCH*WIDTH-1:0] q1, q3;
    logic [NCH-1:0]       qv1, qv3;
    logic [1:0]           rp1, rp3;

    always #5 clk = ~clk;

    reg_fanout_bank #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(1), .RST_VAL(RST_VAL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .ch_en(ch_en),
        .d_valid(d_valid), .d(d), .q(q1), .q_valid(qv1), .rr_ptr(rp1)
    );

    reg_fanout_bank #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(3), .RST_VAL(RST_VAL)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .ch_en(ch_en),
        .d_valid(d_valid), .d(d), .q(q3), .q_valid(qv3), .rr_ptr(rp3)
    );

    // Reference model: a list of scheduled deliveries per instance.
    typedef struct {
        int         due;
        int         inst;
        int         ch;
        logic [7:0] data;
    } ev_t;

    ev_t            pend[$];
    logic [7:0]     mq  [2][NCH];
    logic [NCH-1:0] mqv [2];
    int             mrr [2];
    int             cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int depth_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic void model_clear();
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            mrr[k] = 0;
            for (int c = 0; c < NCH; c++) mq[k][c] = RST_VAL;
        end
    endfunction

    function automatic void model_edge();
        ev_t keep[$];
        ev_t e;
        bit  found;
        int  c;
        cyc++;
        for (int k = 0; k < 2; k++) mqv[k] = '0;
        if (!rst_n || clr) begin
            model_clear();
            return;
        end
        if (d_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (mode == 1'b0) begin
                    for (int ch = 0; ch < NCH; ch++) begin
                        if (ch_en[ch]) begin
                            e = '{due: cyc + depth_of(k) - 1, inst: k, ch: ch, data: d};
                            pend.push_back(e);
                        end
                    end
                end else begin
                    found = 0;
                    for (int off = 0; off < NCH; off++) begin
                        c = (mrr[k] + off) % NCH;
                        if (!found && ch_en[c]) begin
                            found = 1;
                            e = '{due: cyc + depth_of(k) - 1, inst: k, ch: c, data: d};
                            pend.push_back(e);
                            mrr[k] = (c + 1) % NCH;
                        end
                    end
                end
            end
        end
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                mq[pend[i].inst][pend[i].ch] = pend[i].data;
                mqv[pend[i].inst][pend[i].ch] = 1'b1;
            end else begin
                keep.push_back(pend[i]);
            end
        end
        pend = keep;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] packed_q(input int inst);
        logic [NCH*WIDTH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch*WIDTH +: WIDTH] = mq[inst][ch];
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, check just after it.
    task automatic step(input logic r, input logic cl, input logic m,
                        input logic [NCH-1:0] en, input logic dv, input logic [7:0] data);
        rst_n   = r;
        clr     = cl;
        mode    = m;
        ch_en   = en;
        d_valid = dv;
        d       = data;
        @(posedge clk);
        model_edge();
        #1;
        check_val("q_depth1",       64'(q1),  64'(packed_q(0)));
        check_val("q_valid_depth1", 64'(qv1), 64'(mqv[0]));
        check_val("rr_ptr_depth1",  64'(rp1), 64'(mrr[0]));
        check_val("q_depth3",       64'(q3),  64'(packed_q(1)));
        check_val("q_valid_depth3", 64'(qv3), 64'(mqv[1]));
        check_val("rr_ptr_depth3",  64'(rp3), 64'(mrr[1]));
    endtask

    initial begin
        model_clear();
        for (int k = 0; k < 2; k++) mqv[k] = '0;

        // Reset held with a beat on the input
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b111, 1, 8'hA5);

        // Broadcast single beat
        step(1, 0, 0, 3'b111, 1, 8'h3C);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3'b111, 0, 8'h00);

        // Round-robin over a sparse mask
        step(1, 0, 1, 3'b101, 1, 8'h11);
        step(1, 0, 1, 3'b101, 1, 8'h22);
        step(1, 0, 1, 3'b101, 1, 8'h33);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 3'b101, 0, 8'h00);

        // Back-to-back broadcast beats
        step(1, 0, 0, 3'b111, 1, 8'h01);
        step(1, 0, 0, 3'b111, 1, 8'h02);
        step(1, 0, 0, 3'b111, 1, 8'h03);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 3'b111, 0, 8'h00);

        // clr with a beat, then clr while a beat is in flight
        step(1, 1, 0, 3'b111, 1, 8'hFF);
        step(1, 0, 0, 3'b111, 1, 8'h44);
        step(1, 1, 0, 3'b111, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3'b111, 0, 8'h00);

        // Round-robin with nothing enabled, then a single enabled channel
        step(1, 0, 1, 3'b101, 1, 8'h66);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 3'b000, 1, 8'(8'h70 + i));
        step(1, 0, 1, 3'b010, 1, 8'h55);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 3'b010, 0, 8'h00);

        // Randomized traffic with occasional clr and reset
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(19) == 0),
                 1'($urandom),
                 3'($urandom),
                 ($urandom_range(3) != 0),
                 8'($urandom));
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 3'b000, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
